// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared encodings for the MIPS ALU control unit: alu_op classes from main
// control, R-type func codes, ALU control codes and the mult/div sequencer
// state type.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  // alu_op classes driven by the main control unit
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_ADD_I = 3'b101;
  localparam logic [2:0] OP_AND_I = 3'b100;
  localparam logic [2:0] OP_OR_I  = 3'b110;
  localparam logic [2:0] OP_SUB_B = 3'b001;
  localparam logic [2:0] OP_SUB_X = 3'b111;

  // R-type func field values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // ALU control codes
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SLT     = 4'b0110;
  localparam logic [3:0] ALU_MULT    = 4'b0111;
  localparam logic [3:0] ALU_DIV     = 4'b1000;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // Multi-cycle sequencer states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational {alu_op, func} -> ALU control code decoder.
// Ports:
//   i_alu_op  : operation class from main control
//   i_func    : R-type func field (ignored unless i_alu_op is R-type)
//   o_code    : ALU control code (ALU_ILLEGAL for unsupported encodings)
//   o_illegal : encoding is unsupported
//   o_is_md   : decoded op is a multi-cycle mult/div
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6,
  parameter int CTRL_W = 4
) (
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic [FUNC_W-1:0] i_func,
  output logic [CTRL_W-1:0] o_code,
  output logic              o_illegal,
  output logic              o_is_md
);

  logic [CTRL_W-1:0] w_code;

  always_comb begin
    w_code = CTRL_W'(ALU_ILLEGAL);
    if (i_alu_op == OP_W'(OP_RTYPE)) begin
      case (i_func)
        FUNC_W'(FN_ADD):  w_code = CTRL_W'(ALU_ADD);
        FUNC_W'(FN_SUB):  w_code = CTRL_W'(ALU_SUB);
        FUNC_W'(FN_SLL):  w_code = CTRL_W'(ALU_SLL);
        FUNC_W'(FN_SRL):  w_code = CTRL_W'(ALU_SRL);
        FUNC_W'(FN_AND):  w_code = CTRL_W'(ALU_AND);
        FUNC_W'(FN_OR):   w_code = CTRL_W'(ALU_OR);
        FUNC_W'(FN_SLT):  w_code = CTRL_W'(ALU_SLT);
        FUNC_W'(FN_MULT): w_code = CTRL_W'(ALU_MULT);
        FUNC_W'(FN_DIV):  w_code = CTRL_W'(ALU_DIV);
        default:          w_code = CTRL_W'(ALU_ILLEGAL);
      endcase
    end else begin
      case (i_alu_op)
        OP_W'(OP_ADD_I): w_code = CTRL_W'(ALU_ADD);
        OP_W'(OP_AND_I): w_code = CTRL_W'(ALU_AND);
        OP_W'(OP_OR_I):  w_code = CTRL_W'(ALU_OR);
        OP_W'(OP_SUB_B): w_code = CTRL_W'(ALU_SUB);
        OP_W'(OP_SUB_X): w_code = CTRL_W'(ALU_SUB);
        default:         w_code = CTRL_W'(ALU_ILLEGAL);
      endcase
    end
  end

  // The illegal code is never produced by a supported encoding, so it doubles
  // as the illegal flag; mult/div codes only come out of the R-type branch.
  assign o_code    = w_code;
  assign o_illegal = (w_code == CTRL_W'(ALU_ILLEGAL));
  assign o_is_md   = (w_code == CTRL_W'(ALU_MULT)) || (w_code == CTRL_W'(ALU_DIV));

endmodule

// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
// Registered, valid/ready handshaked ALU control unit with a multi-cycle
// mult/div busy sequencer that back-pressures issue.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (accept on in_valid && in_ready)
//   alu_op, func        : request payload from main control / ID stage
//   out_valid/out_ready : result handshake toward the ALU
//   alu_ctrl, illegal   : registered decode result
//   md_busy             : mult/div occupying the ALU
// ---------------------------------------------------------------------------
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W      = 3,
  parameter int FUNC_W    = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              md_busy
);

  logic [CTRL_W-1:0] w_code;
  logic              w_illegal;
  logic              w_is_md;
  logic              w_accept;

  logic              r_out_valid;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_illegal;
  md_state_t         r_state;
  logic [3:0]        r_cnt;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .i_alu_op  (alu_op),
    .i_func    (func),
    .o_code    (w_code),
    .o_illegal (w_illegal),
    .o_is_md   (w_is_md)
  );

  // Issue is blocked while reset is held, while a mult/div occupies the ALU,
  // and while the output register holds a beat the consumer is not taking.
  assign in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output register: a new accept overwrites the slot even in the cycle it
  // is consumed, so back-to-back issue never leaves a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= '0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_ctrl  <= w_code;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Mult/div sequencer: busy for MD_CYCLES cycles starting the edge after
  // acceptance; the counter only ever counts down from MD_CYCLES to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_md && !w_illegal) begin
            r_state <= ST_MD_BUSY;
            r_cnt   <= 4'(MD_CYCLES);
          end
        end
        ST_MD_BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_alu_ctrl;
  assign illegal   = r_illegal;
  assign md_busy   = (r_state == ST_MD_BUSY);

endmodule

// File: tb/tb_alu_control_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_control_seq
// Scoreboard bench: the driver pushes the expected decode of every accepted
// beat into a queue; a separate monitor compares the registered output,
// handshake and busy flags every cycle against that model.
// ---------------------------------------------------------------------------
module tb_alu_control_seq;

  localparam int MD = 4;

  typedef struct {
    logic [3:0] code;
    logic       ill;
    logic       md;
  } exp_t;

  // Decode tables: R-type func -> code, and non-R alu_op -> code
  localparam int RF [9] = '{32, 34, 0, 2, 36, 37, 42, 24, 26};
  localparam int RC [9] = '{ 2,  3, 4, 5,  0,  1,  6,  7,  8};
  localparam int OPV[5] = '{5, 4, 6, 1, 7};
  localparam int OPC[5] = '{2, 0, 1, 3, 3};

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [5:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic       md_busy;

  alu_control_seq #(
    .OP_W      (3),
    .FUNC_W    (6),
    .CTRL_W    (4),
    .MD_CYCLES (MD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .md_busy   (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  exp_t exp_last;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_from  = -1;
  int   busy_until = -2;
  int   or_mode  = 0;   // 0: always ready, 1: random, 2: forced or_val
  logic or_val   = 1'b1;

  function automatic exp_t ref_decode(input int op, input int fn);
    exp_t r;
    r.code = 4'hF;
    r.ill  = 1'b1;
    r.md   = 1'b0;
    if (op == 2) begin
      for (int i = 0; i < 9; i++)
        if (RF[i] == fn) begin
          r.code = 4'(RC[i]);
          r.ill  = 1'b0;
          r.md   = (RC[i] == 7) || (RC[i] == 8);
        end
    end else begin
      for (int i = 0; i < 5; i++)
        if (OPV[i] == op) begin
          r.code = 4'(OPC[i]);
          r.ill  = 1'b0;
        end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge
  always begin
    bit eb;
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_ctrl",  alu_ctrl,  0);
      chk("rst_illegal",   illegal,   0);
      chk("rst_md_busy",   md_busy,   0);
    end else begin
      eb = (cyc >= busy_from) && (cyc <= busy_until);
      chk("md_busy",   md_busy,   eb);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready",  in_ready,  !eb && (q.size() == 0 || out_ready));
      if (q.size() != 0) begin
        chk("alu_ctrl", alu_ctrl, q[0].code);
        chk("illegal",  illegal,  q[0].ill);
        if (out_ready) begin
          exp_last = q[0];
          void'(q.pop_front());
        end
      end else begin
        chk("alu_ctrl_keep", alu_ctrl, exp_last.code);
      end
    end
  end

  task automatic drive_or();
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = or_val;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_or();
      in_valid = 1'b0;
    end
  endtask

  // Present a beat and hold it until accepted; waits = rejected cycles.
  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input bit rnd_in, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    drive_or();
    in_valid = 1'b1;
    alu_op   = op;
    func     = fn;
    forever begin
      #3;
      if (in_ready) begin
        e = ref_decode(int'(alu_op), int'(func));
        q.push_back(e);
        if (e.md) begin
          busy_from  = cyc + 1;
          busy_until = cyc + MD;
        end
        break;
      end
      waits++;
      if (waits > 50) begin
        chk("issue_timeout", waits, 0);
        in_valid = 1'b0;
        break;
      end
      @(negedge clk);
      drive_or();
      if (rnd_in && $urandom_range(0, 3) == 0) begin
        alu_op = 3'($urandom_range(0, 7));
        func   = 6'($urandom_range(0, 63));
      end
    end
  endtask

  initial begin
    int w;
    logic [2:0] op;
    logic [5:0] fn;
    exp_last.code = 4'h0;
    exp_last.ill  = 1'b0;
    exp_last.md   = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 3'd0;
    func      = 6'd0;
    out_ready = 1'b1;
    rst       = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Decode sweep
    for (int i = 0; i < 9; i++) issue(3'd2, 6'(RF[i]), 1'b0, w);
    for (int i = 0; i < 5; i++) issue(3'(OPV[i]), 6'($urandom_range(0, 63)), 1'b0, w);
    issue(3'b010, 6'b100111, 1'b0, w);
    issue(3'b000, 6'b100000, 1'b0, w);
    issue(3'b011, 6'b100000, 1'b0, w);
    idle(MD + 2);

    // Back-to-back add then sub
    issue(3'b010, 6'b100000, 1'b0, w);
    issue(3'b010, 6'b100010, 1'b0, w);
    chk("b2b_wait", w, 0);
    idle(2);

    // Back-pressure: or held for 3 cycles, next beat goes on release
    issue(3'b110, 6'd0, 1'b0, w);
    or_mode = 2;
    or_val  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      drive_or();
      in_valid = 1'b1;
      alu_op   = 3'b010;
      func     = 6'b100000;
      #3;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold",     alu_ctrl, 4'b0001);
    end
    or_mode = 0;
    issue(3'b010, 6'b100000, 1'b0, w);
    chk("bp_release_wait", w, 0);
    idle(2);

    // mult occupies the ALU; pending add goes right after busy falls
    issue(3'b010, 6'b011000, 1'b0, w);
    issue(3'b010, 6'b100000, 1'b0, w);
    chk("md_wait", w, MD);
    idle(3);

    // Reset two cycles into a div, output held by back-pressure
    or_mode = 2;
    or_val  = 1'b0;
    issue(3'b010, 6'b011010, 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    chk("pre_rst_busy", md_busy, 1);
    rst = 1'b1;
    #1;
    chk("async_md_busy",   md_busy,   0);
    chk("async_out_valid", out_valid, 0);
    chk("async_illegal",   illegal,   0);
    q.delete();
    busy_from     = -1;
    busy_until    = -2;
    exp_last.code = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    or_mode = 0;
    out_ready = 1'b1;
    idle(2);

    // Randomized traffic with random back-pressure
    or_mode = 1;
    repeat (300) begin
      if ($urandom_range(0, 9) < 6) begin
        op = 3'b010;
        fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                         : 6'(RF[$urandom_range(0, 8)]);
      end else begin
        op = 3'($urandom_range(0, 7));
        fn = 6'($urandom_range(0, 63));
      end
      issue(op, fn, 1'b1, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    or_mode = 0;
    idle(MD + 4);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, handshaked ALU control unit for the MIPS datapath.
- Decodes {alu_op, func} into the ALU control code.
- Adds multiply/divide decode and a multi-cycle busy sequencer that back-pressures issue.
- Flags illegal encodings.
- Sits between the main control/ID stage and the ALU.

Parameters:
- OP_W, 3, width of alu_op.
- FUNC_W, 6, width of the R-type func field.
- CTRL_W, 4, width of the ALU control code.
- MD_CYCLES, 4, cycles the ALU is occupied by mult/div; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- alu_op  in  OP_W  ALU operation class from main control.
- func  in  FUNC_W  instruction func field.
- out_valid  out  1  alu_ctrl/illegal valid.
- out_ready  in  1  consumer takes output when out_valid && out_ready.
- alu_ctrl  out  CTRL_W  ALU control code.
- illegal  out  1  decoded encoding is unsupported.
- md_busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async assert, sync deassert):
  - out_valid=0, alu_ctrl=0000, illegal=0, md_busy=0, state=IDLE, counter=0.
  - in_ready=0 while rst is high.
- Decode when alu_op=010 (R-type), by func:
  - 100000 -> 0010 (add)
  - 100010 -> 0011 (sub)
  - 000000 -> 0100 (sll)
  - 000010 -> 0101 (srl)
  - 100100 -> 0000 (and)
  - 100101 -> 0001 (or)
  - 101010 -> 0110 (slt)
  - 011000 -> 0111 (mult)
  - 011010 -> 1000 (div)
  - any other func -> 1111 with illegal=1.
- Decode for other alu_op values (func ignored):
  - 101 -> 0010
  - 100 -> 0000
  - 110 -> 0001
  - 001 -> 0011
  - 111 -> 0011
  - 000 or 011 -> 1111 with illegal=1.
- Handshake and output register:
  - in_ready = !rst && !md_busy && (!out_valid || out_ready), combinational.
  - On accept, alu_ctrl and illegal are registered and out_valid=1 on the next edge. Latency is 1 cycle.
  - When out_valid && !out_ready, alu_ctrl and illegal hold stable.
  - Consume with no accept in the same cycle -> out_valid=0 next edge; alu_ctrl keeps its last value.
  - Consume and accept in the same cycle -> out_valid stays 1 with the new data. No bubble.
- FSM, states IDLE and MD_BUSY:
  - IDLE -> MD_BUSY on accept of a legal mult/div (codes 0111, 1000); counter loads MD_CYCLES.
  - In MD_BUSY the counter decrements each cycle. When counter==1 it transitions to IDLE and the counter goes to 0.
  - md_busy = (state==MD_BUSY). It is high for exactly MD_CYCLES cycles, starting the edge after acceptance.
  - in_ready first rises in the cycle after md_busy falls, provided the output is free.
  - An illegal encoding never enters MD_BUSY.
- Boundaries:
  - MD_CYCLES=1 -> single busy cycle.
  - Counter width is 4 bits; no wrap, since it only decrements from MD_CYCLES to 0.
  - in_valid while busy is ignored; the requester holds its inputs.
  - Reset during MD_BUSY -> immediate IDLE and all outputs cleared.
  - Changing inputs while in_valid && !in_ready is permitted; only the accepted beat is sampled.

Decomposition:
- Package alu_ctrl_pkg holds:
  - alu_op class constants (OP_RTYPE=010, etc.)
  - func constants (FN_ADD, FN_SUB, FN_SLL, FN_SRL, FN_AND, FN_OR, FN_SLT, FN_MULT, FN_DIV)
  - ALU code constants (ALU_AND=0000 … ALU_DIV=1000, ALU_ILLEGAL=1111)
  - FSM state enum.
- Sub-module alu_ctrl_decode: a purely combinational {alu_op, func} -> {code, illegal, is_md} decoder.
- The top level holds the handshake register, FSM and counter.

Test Plan:
- Reset then idle:
  - Check every output at its reset value and in_ready=0 during rst.
  - in_ready=1 the cycle after release with out_valid=0.
- Full decode sweep with out_ready=1:
  - All 9 R-type funcs plus the 5 non-R alu_op values give the listed codes one cycle after accept.
  - func=100111 with alu_op=010, and alu_op=000, each give alu_ctrl=1111, illegal=1.
- Back-to-back issue, add then sub with out_ready=1:
  - out_valid stays 1 for 2 cycles; alu_ctrl goes 0010 then 0011.
- Back-pressure:
  - Accept or (0001), then hold out_ready=0 for 3 cycles.
  - alu_ctrl stays 0001, in_ready=0, out_valid=1; the next beat is accepted in the cycle out_ready=1.
- mult with MD_CYCLES=4:
  - alu_ctrl=0111, md_busy=1 for exactly 4 cycles, in_ready=0 throughout.
  - A pending add is accepted in the first cycle after md_busy falls.
- Reset mid-op:
  - Assert rst 2 cycles into a div.
  - md_busy, out_valid and illegal drop immediately (asynchronously); after release, state is IDLE and in_ready=1.
